mem_arbiter: RTL and testbench

- Arbitrates a single-ported RAM between the datapath's instruction-fetch request and its data load/store request.
- Sits between the datapath_cache_if request signals (imemREN, dmemREN, dmemWEN) and the RAM port.
- Data requests have priority over instruction requests.
- Each transfer completes with a one-cycle hit pulse to the winning requester.

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data requests outrank instruction fetches, one access in flight.
// Optional fetch starvation guard enabled by defining MEM_ARBITER_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int WORD_W       = 32,
  parameter int TIMEOUT      = 255,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic [WORD_W-1:0] iload,
  output logic              ihit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic [WORD_W-1:0] dload,
  output logic              dhit,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              bus_err
);

  localparam int CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, IACC, DACC, RESP} state_t;

  state_t              state_q;
  logic [CntW-1:0]     waitCnt_q;
  logic [CntW-1:0]     waitCnt_d;
  logic [WORD_W-1:0]   addr_q;
  logic [WORD_W-1:0]   store_q;
  logic                isWrite_q;
  logic [WORD_W-1:0]   iload_q;
  logic [WORD_W-1:0]   dload_q;
  logic                ihit_q;
  logic                dhit_q;
  logic                ramREN_q;
  logic                ramWEN_q;
  logic                busErr_q;

  logic dReq;
  logic forceFetch;
  logic grantD;
  logic grantI;
  logic timeout;

  assign dReq      = dREN | dWEN;
  assign grantD    = dReq && !forceFetch;
  assign grantI    = iREN && (!dReq || forceFetch);
  assign waitCnt_d = waitCnt_q + 1'b1;
  assign timeout   = (waitCnt_d == CntW'(TIMEOUT));

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  localparam int StarveW = $clog2(STARVE_LIMIT + 1);

  logic [StarveW-1:0] starveCnt_q;

  assign forceFetch = iREN && (starveCnt_q == StarveW'(STARVE_LIMIT));

  // Counts back-to-back data grants that left a fetch waiting; never exceeds the limit.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starveCnt_q <= '0;
    end else if (state_q == IDLE) begin
      if (grantI) begin
        starveCnt_q <= '0;
      end else if (grantD) begin
        starveCnt_q <= iREN ? starveCnt_q + 1'b1 : '0;
      end
    end
  end
`else
  assign forceFetch = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
      addr_q    <= '0;
      store_q   <= '0;
      isWrite_q <= 1'b0;
      iload_q   <= '0;
      dload_q   <= '0;
      ihit_q    <= 1'b0;
      dhit_q    <= 1'b0;
      ramREN_q  <= 1'b0;
      ramWEN_q  <= 1'b0;
      busErr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          waitCnt_q <= '0;
          if (grantD) begin
            addr_q    <= daddr;
            store_q   <= dstore;
            isWrite_q <= dWEN;
            ramWEN_q  <= dWEN;
            ramREN_q  <= !dWEN;
            state_q   <= DACC;
          end else if (grantI) begin
            addr_q    <= iaddr;
            isWrite_q <= 1'b0;
            ramREN_q  <= 1'b1;
            state_q   <= IACC;
          end
        end
        IACC, DACC: begin
          waitCnt_q <= waitCnt_d;
          // A timed-out access still completes with a hit so the requester never deadlocks.
          if (ram_ready || timeout) begin
            ramREN_q <= 1'b0;
            ramWEN_q <= 1'b0;
            state_q  <= RESP;
            if (!ram_ready) begin
              busErr_q <= 1'b1;
            end
            if (state_q == IACC) begin
              ihit_q  <= 1'b1;
              iload_q <= ram_ready ? ramload : '0;
            end else begin
              dhit_q <= 1'b1;
              if (!ram_ready) begin
                dload_q <= '0;
              end else if (!isWrite_q) begin
                dload_q <= ramload;
              end
            end
          end
        end
        RESP: begin
          ihit_q  <= 1'b0;
          dhit_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign iload    = iload_q;
  assign ihit     = ihit_q;
  assign dload    = dload_q;
  assign dhit     = dhit_q;
  assign ramREN   = ramREN_q;
  assign ramWEN   = ramWEN_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign bus_err  = busErr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of who wins, what the RAM sees and what returns.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic        ram_ready = 1'b0;
  logic [31:0] iaddr = '0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic [31:0] ramload = '0;
  logic [31:0] iload;
  logic [31:0] dload;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        ihit;
  logic        dhit;
  logic        ramREN;
  logic        ramWEN;
  logic        bus_err;

  int          assertCount = 0;
  int          failCount = 0;
  logic [31:0] modelI = '0;
  logic [31:0] modelD = '0;

  mem_arbiter #(.WORD_W(32), .TIMEOUT(255), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  // Advance to just past the next rising edge, where outputs are stable and inputs may change.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit ir, input bit dr, input bit dw,
                               input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds);
    iREN   = ir;
    dREN   = dr;
    dWEN   = dw;
    iaddr  = ia;
    daddr  = da;
    dstore = ds;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " ihit"}, 32'(ihit), 32'd0);
    checkOutput({tag, " dhit"}, 32'(dhit), 32'd0);
    checkOutput({tag, " ramREN"}, 32'(ramREN), 32'd0);
    checkOutput({tag, " ramWEN"}, 32'(ramWEN), 32'd0);
    checkOutput({tag, " ramaddr"}, ramaddr, 32'd0);
    checkOutput({tag, " ramstore"}, ramstore, 32'd0);
    checkOutput({tag, " iload"}, iload, 32'd0);
    checkOutput({tag, " dload"}, dload, 32'd0);
    checkOutput({tag, " bus_err"}, 32'(bus_err), 32'd0);
  endtask

  // Called in an IDLE cycle with requests already driven; returns in the following IDLE cycle.
  task automatic serve(input string tag, input bit expD, input bit expW,
                       input logic [31:0] addr, input logic [31:0] store,
                       input logic [31:0] load, input int lat);
    tick();
    checkOutput({tag, " grant ramREN"}, 32'(ramREN), 32'(!expW));
    checkOutput({tag, " grant ramWEN"}, 32'(ramWEN), 32'(expW));
    checkOutput({tag, " grant ramaddr"}, ramaddr, addr);
    if (expW) checkOutput({tag, " grant ramstore"}, ramstore, store);
    checkOutput({tag, " no early hit"}, {30'd0, ihit, dhit}, 32'd0);
    repeat (lat) tick();
    if (lat > 0) begin
      checkOutput({tag, " held strobes"}, {30'd0, ramREN, ramWEN}, {30'd0, !expW, expW});
      checkOutput({tag, " held ramaddr"}, ramaddr, addr);
    end
    ram_ready = 1'b1;
    ramload   = load;
    tick();
    ram_ready = 1'b0;
    ramload   = $urandom;
    if (expD) begin
      if (!expW) modelD = load;
    end else begin
      modelI = load;
    end
    checkOutput({tag, " hit pair"}, {30'd0, ihit, dhit}, {30'd0, !expD, expD});
    checkOutput({tag, " strobes off"}, {30'd0, ramREN, ramWEN}, 32'd0);
    checkOutput({tag, " iload"}, iload, modelI);
    checkOutput({tag, " dload"}, dload, modelD);
    tick();
    checkOutput({tag, " hit ends"}, {30'd0, ihit, dhit}, 32'd0);
  endtask

  bit          rIr;
  bit          rDr;
  bit          rDw;
  int          rLat;
  int          waitCycles;
  logic [31:0] rIa;
  logic [31:0] rDa;
  logic [31:0] rDs;

  initial begin
    $display("[TB] start");
    #2;
    checkResetState("reset");
    tick();
    nRST = 1'b1;

    applyStimulus(1, 0, 0, 32'h40, 32'h0, 32'h0);
    serve("fetch", 0, 0, 32'h40, 32'h0, 32'h8C220004, 1);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0);

    applyStimulus(0, 0, 1, 32'h0, 32'h100, 32'hDEADBEEF);
    serve("store", 1, 1, 32'h100, 32'hDEADBEEF, 32'h55AA55AA, 2);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0);

    applyStimulus(1, 1, 0, 32'h80, 32'h200, 32'h0);
    serve("contend data", 1, 0, 32'h200, 32'h0, 32'h1234, 0);
    applyStimulus(1, 0, 0, 32'h80, 32'h0, 32'h0);
    serve("contend fetch", 0, 0, 32'h80, 32'h0, 32'h0BADF00D, 0);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0);

    applyStimulus(1, 1, 0, 32'h400, 32'h500, 32'h0);
`ifdef MEM_ARBITER_STARVE_GUARD_EN
    for (int k = 0; k < 4; k++) serve("starve data", 1, 0, 32'h500, 32'h0, $urandom, 0);
    serve("starve forced fetch", 0, 0, 32'h400, 32'h0, $urandom, 0);
`else
    for (int k = 0; k < 5; k++) serve("priority data", 1, 0, 32'h500, 32'h0, $urandom, 0);
    applyStimulus(1, 0, 0, 32'h400, 32'h0, 32'h0);
    serve("priority fetch", 0, 0, 32'h400, 32'h0, $urandom, 0);
`endif
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0);

    for (int t = 0; t < 40; t++) begin
      rIr  = 1'($urandom_range(0, 1));
      rDr  = 1'($urandom_range(0, 1));
      rDw  = ($urandom_range(0, 3) == 0);
      rLat = $urandom_range(0, 3);
      rIa  = $urandom;
      rDa  = $urandom;
      rDs  = $urandom;
      applyStimulus(rIr, rDr, rDw, rIa, rDa, rDs);
      if (rDr || rDw) begin
        serve("rnd data", 1, rDw, rDa, rDs, $urandom, rLat);
        if (rIr) begin
          applyStimulus(1, 0, 0, rIa, rDa, rDs);
          serve("rnd deferred fetch", 0, 0, rIa, 32'h0, $urandom, rLat);
        end
      end else if (rIr) begin
        serve("rnd fetch", 0, 0, rIa, 32'h0, $urandom, rLat);
      end else begin
        ram_ready = 1'($urandom_range(0, 1));
        ramload   = $urandom;
        tick();
        ram_ready = 1'b0;
        checkOutput("rnd idle quiet", {28'd0, ihit, dhit, ramREN, ramWEN}, 32'd0);
      end
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0);
    end

    applyStimulus(0, 1, 0, 32'h0, 32'h300, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0);
    waitCycles = 0;
    while (ramREN === 1'b1 && waitCycles < 400) begin
      waitCycles++;
      if (waitCycles == 100) checkOutput("timeout bus_err low while waiting", 32'(bus_err), 32'd0);
      tick();
    end
    modelD = '0;
    checkOutput("timeout strobe cycles", 32'(waitCycles), 32'd255);
    checkOutput("timeout dhit", 32'(dhit), 32'd1);
    checkOutput("timeout ihit", 32'(ihit), 32'd0);
    checkOutput("timeout dload", dload, 32'd0);
    checkOutput("timeout bus_err", 32'(bus_err), 32'd1);
    tick();
    checkOutput("timeout dhit single", 32'(dhit), 32'd0);
    checkOutput("timeout bus_err sticky", 32'(bus_err), 32'd1);
    applyStimulus(1, 0, 0, 32'h600, 32'h0, 32'h0);
    serve("fetch after timeout", 0, 0, 32'h600, 32'h0, 32'hCAFEF00D, 1);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0);
    checkOutput("bus_err still sticky", 32'(bus_err), 32'd1);

    applyStimulus(0, 1, 0, 32'h0, 32'h44, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0);
    checkOutput("midreset in access", 32'(ramREN), 32'd1);
    tick();
    nRST = 1'b0;
    #1;
    modelI = '0;
    modelD = '0;
    checkResetState("midreset");
    #1;
    nRST      = 1'b1;
    ram_ready = 1'b1;
    ramload   = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("after reset quiet", {28'd0, ihit, dhit, ramREN, ramWEN}, 32'd0);
    end
    ram_ready = 1'b0;
    checkOutput("after reset dload", dload, modelD);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
